instruction_fetch: RTL and testbench

Sequential fetch stage ahead of the control unit in the CPU datapath. Holds the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. Presents the held instruction and its 6-bit opcode to the control unit and downstream stages, then computes the next PC from the `branch`, `jump` and ALU `zero` results when the instruction is consumed. Also keeps a retired-instruction counter for debug and performance.

---
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches instruction words over req/ack,
// and resolves the next PC from jump/branch/zero on consume.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks branch when the decoder raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        else if (branch && zero)
            next_pc = pc_plus4 + br_off;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req      = (state_q == FETCH);
    assign instr_valid   = (state_q == HOLD);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[31:26];
    assign retired_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; three instances differ only in
// RESET_PC so the jump and wrap cases can start from their own PCs.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ack = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        zero = 1'b0;

    logic        req   [3];
    logic        valid [3];
    logic [31:0] addr  [3];
    logic [31:0] ins   [3];
    logic [5:0]  opc   [3];
    logic [31:0] pco   [3];
    logic [31:0] ret   [3];

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;
    int c;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instruction_fetch #(
            .RESET_PC(g == 0 ? 32'h0000_0000 :
                      g == 1 ? 32'h1000_0008 : 32'hFFFF_FFFC)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .imem_req(req[g]),
            .imem_addr(addr[g]),
            .imem_ack(imem_ack),
            .imem_rdata(imem_rdata),
            .instr_valid(valid[g]),
            .instr(ins[g]),
            .opcode(opc[g]),
            .pc(pco[g]),
            .instr_ack(instr_ack),
            .branch(branch),
            .jump(jump),
            .zero(zero),
            .retired_count(ret[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_ret = 0;
    endtask

    task automatic fetch(input logic [31:0] w, input int lat,
                         output int cyc);
        int k = 0;
        imem_rdata = w;
        while (valid[0] !== 1'b1 && k < 20) begin
            imem_ack = (k >= lat);
            tick();
            k++;
        end
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_valid", {31'b0, valid[0]}, 32'd1);
        chk("instr", ins[0], w);
        chk("opcode", {26'b0, opc[0]}, {26'b0, w[31:26]});
        cyc = k;
    endtask

    task automatic consume(input logic br, input logic jp, input logic zr);
        branch = br;
        jump = jp;
        zero = zr;
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        zero = 1'b0;
        exp_ret++;
        chk("valid_fall", {31'b0, valid[0]}, 32'd0);
        chk("req_rise", {31'b0, req[0]}, 32'd1);
        chk("retired", ret[0], exp_ret);
    endtask

    initial begin
        logic [31:0] wds [3];
        wds[0] = 32'h0000_1111;
        wds[1] = 32'h8C00_0022;
        wds[2] = 32'hAC00_0033;

        // asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_req", {31'b0, req[0]}, 32'd0);
        chk("rst_valid", {31'b0, valid[0]}, 32'd0);
        chk("rst_pc", pco[0], 32'h0);
        chk("rst_instr", ins[0], 32'h0);
        chk("rst_ret", ret[0], 32'h0);
        tick();
        rst = 1'b0;
        chk("idle_req", {31'b0, req[0]}, 32'd0);
        tick();
        chk("fetch_req", {31'b0, req[0]}, 32'd1);
        chk("fetch_addr", addr[0], 32'h0);

        // zero-latency sequential fetch
        for (int i = 0; i < 3; i++) begin
            chk("seq0_addr", addr[0], i * 4);
            fetch(wds[i], 0, c);
            consume(1'b0, 1'b0, 1'b0);
            chk("seq0_cycles", c + 1, 32'd2);
            if (i == 0) chk("pc_wrap", addr[2], 32'h0);
        end
        chk("seq0_ret", ret[0], 32'd3);

        // three wait states per fetch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("seq3_addr", addr[0], i * 4);
            fetch(wds[i], 3, c);
            consume(1'b0, 1'b0, 1'b0);
            chk("seq3_cycles", c + 1, 32'd5);
        end
        chk("seq3_ret", ret[0], 32'd3);

        // jump to 0x20, then the three branch cases
        fetch(32'h0800_0008, 0, c);
        consume(1'b0, 1'b1, 1'b0);
        chk("jmp_20", addr[0], 32'h20);
        fetch(32'h1000_0003, 0, c);
        consume(1'b1, 1'b0, 1'b1);
        chk("br_taken", addr[0], 32'h30);
        fetch(32'h0800_0008, 0, c);
        consume(1'b0, 1'b1, 1'b0);
        fetch(32'h1000_0003, 1, c);
        consume(1'b1, 1'b0, 1'b0);
        chk("br_not_taken", addr[0], 32'h24);
        fetch(32'h0800_0008, 0, c);
        consume(1'b0, 1'b1, 1'b0);
        fetch(32'h1000_FFFF, 0, c);
        consume(1'b1, 1'b0, 1'b1);
        chk("br_back", addr[0], 32'h20);

        // stray handshakes
        instr_ack = 1'b1;
        tick();
        instr_ack = 1'b0;
        chk("ign_ack_req", {31'b0, req[0]}, 32'd1);
        chk("ign_ack_valid", {31'b0, valid[0]}, 32'd0);
        chk("ign_ack_pc", pco[0], 32'h20);
        chk("ign_ack_ret", ret[0], exp_ret);
        fetch(32'h8C00_0055, 0, c);
        imem_rdata = 32'h1234_5678;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("ign_mem_instr", ins[0], 32'h8C00_0055);
        chk("ign_mem_valid", {31'b0, valid[0]}, 32'd1);
        consume(1'b0, 1'b0, 1'b0);

        // jump beats branch
        do_reset();
        fetch(32'h0800_0040, 0, c);
        consume(1'b1, 1'b1, 1'b1);
        chk("jmp_prio", addr[1], 32'h1000_0100);
        chk("jmp_u0", addr[0], 32'h0000_0100);

        // reset in the middle of a fetch, late ack ignored
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, req[0]}, 32'd0);
        chk("mid_rst_pc", pco[0], 32'h0);
        chk("mid_rst_ret", ret[0], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
        imem_rdata = 32'hAC00_0077;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'b0, valid[0]}, 32'd0);
        chk("late_ack_req", {31'b0, req[0]}, 32'd1);
        chk("late_ack_instr", ins[0], 32'h0);
        chk("refetch_addr", addr[0], 32'h0);
        fetch(32'hAC00_0077, 0, c);
        consume(1'b0, 1'b0, 1'b0);
        chk("refetch_next", addr[0], 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
